// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: opcode classes, funct3 access encodings, FSM state
// and the alignment/strobe helpers used by the request path.
package risc_v_mem_pkg;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

    // Reserved funct3 codes are reported as not ok, so they take the misaligned path.
    function automatic logic access_ok(input logic is_store, input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_LB:   ok = 1'b1;
            F3_LH:   ok = !offset[0];
            F3_LW:   ok = (offset == 2'b00);
            F3_LBU:  ok = !is_store;
            F3_LHU:  ok = !is_store && !offset[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [3:0] store_strobe(input logic [2:0] funct3, input logic [1:0] offset);
        logic [3:0] strb;
        case (funct3)
            F3_SB:   strb = 4'b0001 << offset;
            F3_SH:   strb = 4'b0011 << {offset[1], 1'b0};
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response port between the MEM stage (master) and memory (slave).
interface mem_access_stage_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_we;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [3:0]            mem_req_wstrb;
    logic                  mem_rsp_valid;
    logic [DATA_WIDTH-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );

    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata, mem_req_wstrb,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/mem_access_stage_load_align.sv
// Load formatter: picks the addressed byte/half from the raw word and sign/zero-extends it.
module mem_load_align
    import risc_v_mem_pkg::*;
#(
    parameter int REG_WIDTH = 32
) (
    input  logic [REG_WIDTH-1:0] rdata,
    input  logic [2:0]           funct3,
    input  logic [1:0]           offset,
    output logic [REG_WIDTH-1:0] result
);

    logic [7:0]  lane [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = lane[offset];
    assign half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (funct3)
            F3_LB:   result = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(REG_WIDTH-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(REG_WIDTH-16){1'b0}}, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues loads/stores over a valid/ready port, stalls while an access
// is in flight, formats load data and passes everything else straight to MEM/WB.
module mem_access_stage
    import risc_v_mem_pkg::*;
#(
    parameter int REG_WIDTH      = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [REG_WIDTH-1:0]      EX_MEM_alu_out,
    input  logic [REG_WIDTH-1:0]      EX_MEM_dataB,
    input  logic [6:0]                EX_MEM_inst_opcode,
    input  logic [2:0]                EX_MEM_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] EX_MEM_rd,
    input  logic                      EX_MEM_reg_write_en,
    mem_access_stage_if.master        mem,
    output logic                      mem_stall,
    output logic                      mem_misaligned,
    output logic [REG_WIDTH-1:0]      MEM_result,
    output logic [REG_ADDR_WIDTH-1:0] MEM_rd,
    output logic                      MEM_reg_write_en
);

    mem_state_e            state_q, state_d;
    logic                  req_valid_q, req_valid_d;
    logic                  req_we_q, req_we_d;
    logic [REG_WIDTH-1:0]  req_addr_q, req_addr_d;
    logic [REG_WIDTH-1:0]  req_wdata_q, req_wdata_d;
    logic [3:0]            req_wstrb_q, req_wstrb_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            offset_q, offset_d;

    logic                  is_load, is_store, is_mem, aligned;
    logic [1:0]            offset;
    logic [REG_WIDTH-1:0]  store_data;
    logic [REG_WIDTH-1:0]  load_data;

    assign is_load  = (EX_MEM_inst_opcode == LOAD);
    assign is_store = (EX_MEM_inst_opcode == STORE);
    assign is_mem   = is_load || is_store;
    assign offset   = EX_MEM_alu_out[1:0];
    assign aligned  = access_ok(is_store, EX_MEM_funct3, offset);

    // Replicate the store operand across byte lanes so the strobes alone pick the target bytes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            assign store_data[8*gi +: 8] =
                (EX_MEM_funct3 == F3_SB) ? EX_MEM_dataB[7:0] :
                (EX_MEM_funct3 == F3_SH) ? EX_MEM_dataB[8*(gi%2) +: 8] :
                                           EX_MEM_dataB[8*gi +: 8];
        end
    endgenerate

    mem_load_align #(
        .REG_WIDTH (REG_WIDTH)
    ) u_load_align (
        .rdata  (mem.mem_rsp_rdata),
        .funct3 (funct3_q),
        .offset (offset_q),
        .result (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            req_wstrb_q <= '0;
            funct3_q    <= '0;
            offset_q    <= '0;
        end else begin
            state_q     <= state_d;
            req_valid_q <= req_valid_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            req_wstrb_q <= req_wstrb_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_valid_d = req_valid_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        req_wstrb_d = req_wstrb_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        case (state_q)
            IDLE: begin
                if (is_mem && aligned) begin
                    state_d     = REQ;
                    req_valid_d = 1'b1;
                    req_we_d    = is_store;
                    req_addr_d  = {EX_MEM_alu_out[REG_WIDTH-1:2], 2'b00};
                    req_wdata_d = is_store ? store_data : '0;
                    req_wstrb_d = is_store ? store_strobe(EX_MEM_funct3, offset) : 4'b0000;
                    funct3_d    = EX_MEM_funct3;
                    offset_d    = offset;
                end
            end
            REQ: begin
                if (mem.mem_req_ready) begin
                    req_valid_d = 1'b0;
                    state_d     = req_we_q ? IDLE : WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (mem.mem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // While reset is high the stage behaves as an idle pass-through with no stall or fault.
    always_comb begin
        mem_stall        = 1'b0;
        mem_misaligned   = 1'b0;
        MEM_result       = EX_MEM_alu_out;
        MEM_rd           = EX_MEM_rd;
        MEM_reg_write_en = EX_MEM_reg_write_en;
        if (reset) begin
            if (is_mem) begin
                MEM_reg_write_en = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (is_mem) begin
                        MEM_reg_write_en = 1'b0;
                        mem_stall        = aligned;
                        mem_misaligned   = !aligned;
                    end
                end
                REQ: begin
                    MEM_reg_write_en = 1'b0;
                    mem_stall        = !(mem.mem_req_ready && req_we_q);
                end
                WAIT_RSP: begin
                    if (mem.mem_rsp_valid) begin
                        MEM_result = load_data;
                    end else begin
                        mem_stall        = 1'b1;
                        MEM_reg_write_en = 1'b0;
                    end
                end
                default: MEM_reg_write_en = 1'b0;
            endcase
        end
    end

    assign mem.mem_req_valid = req_valid_q;
    assign mem.mem_req_we    = req_we_q;
    assign mem.mem_req_addr  = req_addr_q;
    assign mem.mem_req_wdata = req_wdata_q;
    assign mem.mem_req_wstrb = req_wstrb_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed vector table, reset corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_mem_access_stage;
    import risc_v_mem_pkg::*;

    localparam logic [6:0] OP_ADD = 7'b0110011;

    typedef struct {
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] dataB;
        logic [4:0]  rd;
        logic        rwe;
        int          rdy_dly;
        int          rsp_dly;
        logic [31:0] rdata;
        int          exp_stalls;
        logic        exp_req;
        logic [31:0] exp_wdata;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_res;
        logic        exp_we;
        logic        exp_mis;
        logic        chk_res;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ex_alu, ex_dataB;
    logic [6:0]  ex_opc;
    logic [2:0]  ex_f3;
    logic [4:0]  ex_rd;
    logic        ex_rwe;
    logic        stall_o, mis_o, rwe_o;
    logic [31:0] res_o;
    logic [4:0]  rd_o;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    mem_access_stage_if #(.DATA_WIDTH(32)) mif ();

    mem_access_stage #(
        .REG_WIDTH      (32),
        .REG_ADDR_WIDTH (5)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .EX_MEM_alu_out      (ex_alu),
        .EX_MEM_dataB        (ex_dataB),
        .EX_MEM_inst_opcode  (ex_opc),
        .EX_MEM_funct3       (ex_f3),
        .EX_MEM_rd           (ex_rd),
        .EX_MEM_reg_write_en (ex_rwe),
        .mem                 (mif),
        .mem_stall           (stall_o),
        .mem_misaligned      (mis_o),
        .MEM_result          (res_o),
        .MEM_rd              (rd_o),
        .MEM_reg_write_en    (rwe_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] dataB, input logic [4:0] rd, input logic rwe,
                                 input int rdy, input int rsp, input logic [31:0] rdata,
                                 input int stalls, input logic req, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, input logic [31:0] res, input logic we,
                                 input logic mis, input logic chkres);
        vec_t v;
        v.opcode = opc; v.f3 = f3; v.addr = addr; v.dataB = dataB; v.rd = rd; v.rwe = rwe;
        v.rdy_dly = rdy; v.rsp_dly = rsp; v.rdata = rdata; v.exp_stalls = stalls; v.exp_req = req;
        v.exp_wdata = wdata; v.exp_wstrb = wstrb; v.exp_res = res; v.exp_we = we;
        v.exp_mis = mis; v.chk_res = chkres;
        return v;
    endfunction

    // Reference model: derived from access sizes and byte arithmetic, not from any FSM.
    function automatic vec_t model(input vec_t vi);
        vec_t v;
        int unsigned size, off;
        logic [31:0] b, h;
        logic ld, st, legal;
        v = vi;
        ld = (v.opcode == LOAD);
        st = (v.opcode == STORE);
        size = 1 << v.f3[1:0];
        off  = v.addr % 4;
        legal = ld ? (v.f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (v.f3 <= 3'd2);
        v.exp_req = 0; v.exp_wdata = 0; v.exp_wstrb = 0; v.exp_res = 0;
        v.exp_mis = 0; v.chk_res = 0; v.exp_stalls = 0; v.exp_we = 0;
        if (!ld && !st) begin
            v.exp_res = v.addr; v.exp_we = v.rwe; v.chk_res = 1;
        end else if (!legal || (off % size) != 0) begin
            v.exp_mis = 1;
        end else if (st) begin
            v.exp_req = 1;
            v.exp_stalls = 1 + v.rdy_dly;
            v.exp_wstrb = 4'(((1 << size) - 1) << off);
            v.exp_wdata = (size == 1) ? (v.dataB & 32'hFF) * 32'h01010101 :
                          (size == 2) ? (v.dataB & 32'hFFFF) * 32'h00010001 : v.dataB;
        end else begin
            v.exp_req = 1;
            v.exp_stalls = 2 + v.rdy_dly + v.rsp_dly;
            v.exp_we = v.rwe;
            v.chk_res = 1;
            if (size == 1) begin
                b = (v.rdata >> (8 * off)) & 32'hFF;
                v.exp_res = (!v.f3[2] && b >= 32'd128) ? b - 32'd256 : b;
            end else if (size == 2) begin
                h = (v.rdata >> (8 * off)) & 32'hFFFF;
                v.exp_res = (!v.f3[2] && h >= 32'h8000) ? h - 32'h10000 : h;
            end else begin
                v.exp_res = v.rdata;
            end
        end
        return v;
    endfunction

    // Called at posedge+1; returns at posedge+1 of the cycle after the op retires.
    task automatic run_op(input vec_t v, input string tag);
        int cyc = 0, stalls = 0, req_cnt = 0, wait_cnt = 0;
        logic awaiting = 0, done = 0, req_seen = 0, req_bad = 0, hold_bad = 0;
        logic [31:0] a_res = 0;
        logic [4:0]  a_rd = 0;
        logic        a_we = 0, a_mis = 0;
        logic        is_st;
        is_st = (v.opcode == STORE);
        ex_opc = v.opcode; ex_f3 = v.f3; ex_alu = v.addr; ex_dataB = v.dataB;
        ex_rd = v.rd; ex_rwe = v.rwe;
        while (!done && cyc < 64) begin
            if (awaiting) begin
                mif.mem_rsp_valid = (wait_cnt >= v.rsp_dly);
                mif.mem_rsp_rdata = v.rdata;
                wait_cnt++;
            end else begin
                mif.mem_rsp_valid = 1'($urandom_range(0, 1));
                mif.mem_rsp_rdata = $urandom;
            end
            if (mif.mem_req_valid) begin
                mif.mem_req_ready = (req_cnt >= v.rdy_dly);
                req_cnt++;
            end else begin
                mif.mem_req_ready = 1'($urandom_range(0, 1));
            end
            #4;
            if (mif.mem_req_valid) begin
                req_seen = 1;
                if (mif.mem_req_we !== is_st || mif.mem_req_addr !== (v.addr & ~32'h3)) req_bad = 1;
                if (is_st && (mif.mem_req_wdata !== v.exp_wdata || mif.mem_req_wstrb !== v.exp_wstrb))
                    req_bad = 1;
            end
            if (stall_o) begin
                stalls++;
                if (rwe_o !== 1'b0 || mis_o !== 1'b0) hold_bad = 1;
            end else begin
                done = 1;
                a_res = res_o; a_rd = rd_o; a_we = rwe_o; a_mis = mis_o;
            end
            if (mif.mem_req_valid && mif.mem_req_ready && !is_st) awaiting = 1;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_stalls"}, 32'(stalls), 32'(v.exp_stalls));
        chk({tag, "_req_seen"}, 32'(req_seen), 32'(v.exp_req));
        chk({tag, "_req_contents"}, 32'(req_bad), 32'd0);
        chk({tag, "_stall_outputs"}, 32'(hold_bad), 32'd0);
        chk({tag, "_wb_en"}, 32'(a_we), 32'(v.exp_we));
        chk({tag, "_misaligned"}, 32'(a_mis), 32'(v.exp_mis));
        if (v.chk_res) begin
            chk({tag, "_result"}, a_res, v.exp_res);
            chk({tag, "_rd"}, 32'(a_rd), 32'(v.rd));
        end
    endtask

    vec_t tbl [14];

    initial begin
        vec_t rv;
        tbl[0]  = mkv(OP_ADD, 3'd0, 32'h1234, 0, 5'd5, 1, 0, 0, 0, 0, 0, 0, 4'h0, 32'h1234, 1, 0, 1);
        tbl[1]  = mkv(STORE, 3'd2, 32'h100, 32'hDEADBEEF, 5'd2, 1, 0, 0, 0, 1, 1, 32'hDEADBEEF, 4'b1111, 0, 0, 0, 0);
        tbl[2]  = mkv(STORE, 3'd0, 32'h103, 32'h000000AB, 5'd3, 1, 3, 0, 0, 4, 1, 32'hABABABAB, 4'b1000, 0, 0, 0, 0);
        tbl[3]  = mkv(LOAD, 3'd0, 32'h201, 0, 5'd7, 1, 0, 1, 32'h00008000, 3, 1, 0, 4'h0, 32'hFFFFFF80, 1, 0, 1);
        tbl[4]  = mkv(LOAD, 3'd4, 32'h201, 0, 5'd7, 1, 0, 1, 32'h00008000, 3, 1, 0, 4'h0, 32'h00000080, 1, 0, 1);
        tbl[5]  = mkv(LOAD, 3'd2, 32'h202, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[6]  = mkv(LOAD, 3'd1, 32'h202, 0, 5'd9, 1, 1, 0, 32'h80010000, 3, 1, 0, 4'h0, 32'hFFFF8001, 1, 0, 1);
        tbl[7]  = mkv(LOAD, 3'd5, 32'h200, 0, 5'd10, 1, 0, 2, 32'h1234F00D, 4, 1, 0, 4'h0, 32'h0000F00D, 1, 0, 1);
        tbl[8]  = mkv(LOAD, 3'd2, 32'h300, 0, 5'd11, 1, 0, 0, 32'hCAFEBABE, 2, 1, 0, 4'h0, 32'hCAFEBABE, 1, 0, 1);
        tbl[9]  = mkv(STORE, 3'd1, 32'h102, 32'h12345678, 5'd12, 1, 0, 0, 0, 1, 1, 32'h56785678, 4'b1100, 0, 0, 0, 0);
        tbl[10] = mkv(STORE, 3'd1, 32'h101, 32'h12345678, 5'd13, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[11] = mkv(LOAD, 3'd3, 32'h200, 0, 5'd14, 1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 0);
        tbl[12] = mkv(OP_ADD, 3'd0, 32'hFFFF0000, 0, 5'd0, 0, 0, 0, 0, 0, 0, 0, 4'h0, 32'hFFFF0000, 0, 0, 1);
        tbl[13] = mkv(LOAD, 3'd0, 32'h203, 0, 5'd15, 0, 2, 0, 32'h7F000000, 4, 1, 0, 4'h0, 32'h0000007F, 0, 0, 1);

        // Reset with a misaligned load presented: no stall, no fault pulse.
        reset = 1; ex_opc = LOAD; ex_f3 = 3'd2; ex_alu = 32'h202; ex_dataB = 0; ex_rd = 5'd1; ex_rwe = 1;
        mif.mem_req_ready = 0; mif.mem_rsp_valid = 0; mif.mem_rsp_rdata = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        #4;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_misaligned", 32'(mis_o), 32'd0);
        @(posedge clk); #1;
        reset = 0; ex_opc = OP_ADD; ex_alu = 32'h0000_0042; ex_rd = 5'd4; ex_rwe = 1;
        #4;
        chk("rst_req_valid", 32'(mif.mem_req_valid), 32'd0);
        chk("rst_req_we", 32'(mif.mem_req_we), 32'd0);
        chk("rst_req_addr", mif.mem_req_addr, 32'd0);
        chk("rst_req_wdata", mif.mem_req_wdata, 32'd0);
        chk("rst_req_wstrb", 32'(mif.mem_req_wstrb), 32'd0);
        chk("rst_pass_result", res_o, 32'h42);
        @(posedge clk); #1;

        for (int i = 0; i < 14; i++) run_op(tbl[i], $sformatf("vec%0d", i));

        // Reset while waiting for a load response; the late response must be dropped.
        ex_opc = LOAD; ex_f3 = 3'd2; ex_alu = 32'h400; ex_rd = 5'd9; ex_rwe = 1;
        mif.mem_req_ready = 1; mif.mem_rsp_valid = 0;
        #4; chk("mid_idle_stall", 32'(stall_o), 32'd1);
        @(posedge clk); #1;
        #4; chk("mid_req_valid", 32'(mif.mem_req_valid), 32'd1);
        @(posedge clk); #1;
        reset = 1;
        #4;
        chk("mid_rst_stall", 32'(stall_o), 32'd0);
        chk("mid_rst_wb_en", 32'(rwe_o), 32'd0);
        @(posedge clk); #1;
        reset = 0; ex_opc = OP_ADD; ex_alu = 32'h55; ex_rd = 5'd3; ex_rwe = 1;
        mif.mem_rsp_valid = 1; mif.mem_rsp_rdata = 32'hBAD0BAD0;
        #4;
        chk("mid_after_req_valid", 32'(mif.mem_req_valid), 32'd0);
        chk("mid_after_stall", 32'(stall_o), 32'd0);
        chk("mid_after_result", res_o, 32'h55);
        chk("mid_after_rd", 32'(rd_o), 32'd3);
        chk("mid_after_addr", mif.mem_req_addr, 32'd0);
        @(posedge clk); #1;
        mif.mem_rsp_valid = 0;

        for (int i = 0; i < 200; i++) begin
            int cls;
            cls = $urandom_range(0, 2);
            rv.opcode = (cls == 0) ? OP_ADD : (cls == 1) ? LOAD : STORE;
            rv.f3 = (cls == 2) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            rv.addr = $urandom;
            if ($urandom_range(0, 2) == 0) rv.addr[1:0] = 2'b00;
            rv.dataB = $urandom; rv.rd = 5'($urandom); rv.rwe = 1'($urandom_range(0, 1));
            rv.rdy_dly = $urandom_range(0, 3); rv.rsp_dly = $urandom_range(0, 3);
            rv.rdata = $urandom;
            rv = model(rv);
            run_op(rv, $sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access (MEM) stage of the five-stage RISC-V pipeline, sitting between the EX/MEM and MEM/WB pipeline registers. It issues loads and stores from EX/MEM to the data memory over a valid/ready request port, stalls the pipeline while an access is outstanding, and aligns, sign- or zero-extends load data. It presents the write-back result, rd and write enable to the MEM/WB register. Non-memory instructions pass through with zero added latency.

## Interface
- REG_WIDTH, `REG_WIDTH (32): datapath width.
- REG_ADDR_WIDTH, `REG_ADDR_WIDTH (5): register index width.
- Reset is synchronous and active-high; the block uses one clock.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- EX_MEM_alu_out  in  REG_WIDTH  ALU result, or effective address for load/store.
- EX_MEM_dataB  in  REG_WIDTH  store data (rs2).
- EX_MEM_inst_opcode  in  7  opcode.
- EX_MEM_funct3  in  3  access size and signedness.
- EX_MEM_rd  in  REG_ADDR_WIDTH  destination register.
- EX_MEM_reg_write_en  in  1  write-back enable.
- mem_req_valid  out  1  request valid (registered).
- mem_req_ready  in  1  memory accepts the request.
- mem_req_we  out  1  1 = store.
- mem_req_addr  out  REG_WIDTH  word-aligned address ({addr[31:2],2'b00}).
- mem_req_wdata  out  REG_WIDTH  lane-replicated store data.
- mem_req_wstrb  out  4  byte strobes.
- mem_rsp_valid  in  1  load data valid.
- mem_rsp_rdata  in  REG_WIDTH  raw load word.
- mem_stall  out  1  hold EX/MEM and all upstream stages.
- mem_misaligned  out  1  one-cycle misaligned-access pulse.
- MEM_result  out  REG_WIDTH  write-back value for MEM/WB.
- MEM_rd  out  REG_ADDR_WIDTH  destination register for MEM/WB.
- MEM_reg_write_en  out  1  write-back enable for MEM/WB; 0 means the cycle is a bubble.

## Operation
- Opcode classes: LOAD = 7'b0000011, STORE = 7'b0100011; every other opcode is a pass-through.
- Pass-through: MEM_result = EX_MEM_alu_out and MEM_rd/MEM_reg_write_en come from EX/MEM, all combinational. No stall.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE + aligned load/store: latch request registers. mem_req_addr is the word address. For a store, wdata is replicated (SB: byte ×4, SH: half ×2) and wstrb is SB 4'b0001<<a[1:0], SH 4'b0011<<{a[1],1'b0}, SW 4'b1111. Also latch funct3 and a[1:0]. mem_stall = 1, MEM_reg_write_en = 0. Next state REQ.
- REQ: mem_req_valid = 1, held with stable contents until mem_req_ready.
  - Store accepted: go to IDLE, mem_stall = 0 this cycle, MEM_reg_write_en = 0. Stores never write back.
  - Load accepted: go to WAIT_RSP, mem_stall = 1.
  - Not accepted: stay in REQ, mem_stall = 1.
- WAIT_RSP:
  - mem_rsp_valid = 0: mem_stall = 1.
  - mem_rsp_valid = 1: mem_stall = 0, MEM_result = the formatted mem_rsp_rdata, MEM_rd = EX_MEM_rd, MEM_reg_write_en = EX_MEM_reg_write_en. Go to IDLE.
- Load formatting uses the latched a[1:0]:
  - LB/LBU: select byte, then sign- or zero-extend.
  - LH/LHU: select half a[1], then sign- or zero-extend.
  - LW: whole word.
- Misaligned access (LH/LHU/SH with a[0] = 1; LW/SW with a[1:0] != 0): no request is issued and the FSM stays in IDLE. mem_misaligned = 1 for one cycle, MEM_reg_write_en = 0, no stall.
- Reserved funct3 values are handled as misaligned.
- mem_rsp_valid outside WAIT_RSP is ignored.

## Timing
- Reset values: state IDLE, mem_req_valid = 0, mem_req_we = 0, mem_req_addr/wdata = 0, mem_req_wstrb = 0, latched funct3/offset = 0.
- Combinational outputs during reset (pass-through values aside): mem_stall = 0, mem_misaligned = 0.
- Reset mid-access: FSM returns to IDLE and mem_req_valid drops on the next edge. A response arriving after reset is ignored.
- Store, ready held high: 1 stall cycle, retires in cycle 2.
- Load, ready high and response one cycle after acceptance: 2 stall cycles, result in cycle 3.
- Each extra cycle of ready low or response delay adds exactly one stall cycle.
- mem_stall is combinational from the FSM state and the handshake inputs. EX/MEM inputs are guaranteed stable while mem_stall = 1.
- Back-to-back memory ops: the next op is seen in IDLE on the cycle after completion. There are no idle cycles beyond the stalls above.

## Structure
- Shared package risc_v_mem_pkg holds:
  - opcode constants LOAD/STORE;
  - funct3 encodings LB = 0, LH = 1, LW = 2, LBU = 4, LHU = 5 (SB/SH/SW = 0/1/2);
  - the state enum {IDLE, REQ, WAIT_RSP}.
- One combinational sub-module, mem_load_align (inputs: rdata, funct3, offset; output: formatted result). The FSM, request registers and strobe generation live in the top module.

## Test plan
- ADD, alu_out = 0x1234 → MEM_result 0x1234 in the same cycle, MEM_reg_write_en 1, mem_stall never set.
- SW addr 0x100, dataB 0xDEADBEEF, ready held high → mem_req addr 0x100, wstrb 4'b1111, we = 1. Exactly 1 stall cycle. MEM_reg_write_en = 0.
- SB addr 0x103, dataB 0xAB, ready low for 3 cycles → wdata 0xABABABAB, wstrb 4'b1000. Request contents stable throughout. 4 stall cycles.
- LB addr 0x201, rdata 0x0000_8000, response 2 cycles after acceptance → MEM_result 0xFFFFFF80. Repeat as LBU → 0x00000080.
- LW addr 0x202 → mem_misaligned pulses for 1 cycle, no mem_req_valid, MEM_reg_write_en = 0, no stall.
- Reset asserted while in WAIT_RSP, then rsp_valid arrives → state IDLE, all outputs at reset values, the stale response is not written back.
